// File: rtl/acia_fifo.sv
// MC6850-style serial port with programmable baud divisor, TX/RX FIFOs and 8N1 engines.
// Optional internal loopback (control bit 4) is built only when ACIA_FIFO_LOOPBACK_EN is defined.

module acia_fifo_buf #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    rdata,
   output logic [AW:0]   count
);
   localparam logic [AW:0]   DEPTH    = (AW+1)'(2**AW);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [7:0]    mem_r [2**AW];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s, pop_ok_s;

   // A push into a full buffer is accepted only when a pop frees a slot in the same cycle
   assign push_ok_s = push && ((count_r != DEPTH) || pop);
   assign pop_ok_s  = pop && (count_r != CNT_ZERO);
   assign rdata     = mem_r[rd_ptr_r];
   assign count     = count_r;

   // storage array
   always_ff @(posedge clk) begin
      if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= CNT_ZERO;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module acia_fifo #(
   parameter int CLK_FREQ = 30650000,
   parameter int DEF_BAUD = 115200,
   parameter int DIVW     = 16,
   parameter int FIFO_AW  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       rx,
   output logic       tx,
   output logic       irq
);
   localparam logic [DIVW-1:0]  RST_DIV = DIVW'(CLK_FREQ / DEF_BAUD);
   localparam logic [DIVW-1:0]  MIN_DIV = DIVW'(8);
   localparam logic [DIVW-1:0]  ONE_D   = DIVW'(1);
   localparam logic [DIVW-1:0]  ZERO_D  = DIVW'(0);
   localparam logic [FIFO_AW:0] DEPTH   = (FIFO_AW+1)'(2**FIFO_AW);
   localparam logic [FIFO_AW:0] HALF    = (FIFO_AW+1)'(2**(FIFO_AW-1));
   localparam logic [FIFO_AW:0] EMPTY   = (FIFO_AW+1)'(0);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

   logic rd_s, ctrl_wr_s, data_wr_s, stat_rd_s, data_rd_s, srst_s;
   logic rie_r, ovr_r, fe_r, irq_r, tx_r;
   logic [1:0] txc_r, cds_r;
   logic [DIVW-1:0] div_r, div_new_s;
   logic [15:0] div16_s, div_wide_s;
   logic [7:0] dout_r, last_rd_r, rd_mux_s;
   logic [7:0] txf_rdata, rxf_rdata;
   logic [FIFO_AW:0] txf_count, rxf_count;
   logic txf_empty_s, txf_full_s, rxf_empty_s, rxf_full_s, rx_half_s;

   assign rd_s      = cs && !we;
   assign ctrl_wr_s = cs && we && (addr == 2'd0);
   assign data_wr_s = cs && we && (addr == 2'd1);
   assign stat_rd_s = rd_s && (addr == 2'd0);
   assign data_rd_s = rd_s && (addr == 2'd1);
   // Soft reset acts at the very edge that writes CDS=11 and persists while it is held
   assign srst_s    = ctrl_wr_s ? (din[1:0] == 2'b11) : (cds_r == 2'b11);

`ifdef ACIA_FIFO_LOOPBACK_EN
   logic loop_r, tx_pin_r;
`endif

   // control register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rie_r <= 1'b0;
         txc_r <= 2'b00;
         cds_r <= 2'b00;
`ifdef ACIA_FIFO_LOOPBACK_EN
         loop_r <= 1'b0;
`endif
      end else if (ctrl_wr_s) begin
         rie_r <= din[7];
         txc_r <= din[6:5];
         cds_r <= din[1:0];
`ifdef ACIA_FIFO_LOOPBACK_EN
         loop_r <= din[4];
`endif
      end
   end

   assign div16_s = 16'(div_r);

   // byte-wise divisor update with the minimum bit period enforced
   always_comb begin
      div_wide_s = div16_s;
      if (cs && we && addr == 2'd2) begin
         div_wide_s[7:0] = din;
      end else if (cs && we && addr == 2'd3) begin
         div_wide_s[15:8] = din;
      end else begin
         div_wide_s = div16_s;
      end
      div_new_s = DIVW'(div_wide_s);
      if (div_new_s < MIN_DIV) begin
         div_new_s = MIN_DIV;
      end else begin
         div_new_s = DIVW'(div_wide_s);
      end
   end

   // divisor register
   always_ff @(posedge clk) begin
      if (!rst_n) div_r <= RST_DIV;
      else        div_r <= div_new_s;
   end

   // ---------------- TX engine ----------------
   state_t tx_state_r, tx_next_s;
   logic [DIVW-1:0] tx_cnt_r, tx_bdiv_r;
   logic [7:0] tx_sh_r;
   logic [2:0] tx_bit_r;
   logic tx_tick_s, tx_pop_s, tx_bit_s;

   assign tx_tick_s = (tx_cnt_r == ZERO_D);

   // TX next state
   always_comb begin
      tx_next_s = tx_state_r;
      case (tx_state_r)
         S_IDLE:  tx_next_s = txf_empty_s ? S_IDLE : S_START;
         S_START: tx_next_s = tx_tick_s ? S_DATA : S_START;
         S_DATA:  tx_next_s = (tx_tick_s && tx_bit_r == 3'd7) ? S_STOP : S_DATA;
         S_STOP:  tx_next_s = !tx_tick_s ? S_STOP : (txf_empty_s ? S_IDLE : S_START);
         default: tx_next_s = S_IDLE;
      endcase
   end

   // TX outputs: FIFO pop at frame start and the line level for the current state
   always_comb begin
      tx_pop_s = 1'b0;
      tx_bit_s = 1'b1;
      case (tx_state_r)
         S_IDLE:  tx_pop_s = !txf_empty_s;
         S_START: tx_bit_s = 1'b0;
         S_DATA:  tx_bit_s = tx_sh_r[0];
         S_STOP:  tx_pop_s = tx_tick_s && !txf_empty_s;
         default: tx_bit_s = 1'b1;
      endcase
   end

   // TX state register and datapath
   always_ff @(posedge clk) begin
      if (!rst_n || srst_s) begin
         tx_state_r <= S_IDLE;
         tx_cnt_r   <= ZERO_D;
         tx_bdiv_r  <= MIN_DIV;
         tx_sh_r    <= 8'h00;
         tx_bit_r   <= 3'd0;
         tx_r       <= 1'b1;
      end else begin
         tx_state_r <= tx_next_s;
         tx_r       <= tx_bit_s;
         if (tx_pop_s) begin
            tx_bdiv_r <= div_r;
            tx_cnt_r  <= div_r - ONE_D;
            tx_sh_r   <= txf_rdata;
         end else if (tx_state_r != S_IDLE) begin
            if (tx_tick_s) begin
               tx_cnt_r <= tx_bdiv_r - ONE_D;
               if (tx_state_r == S_START) tx_bit_r <= 3'd0;
               if (tx_state_r == S_DATA) begin
                  tx_sh_r  <= {1'b0, tx_sh_r[7:1]};
                  tx_bit_r <= tx_bit_r + 3'd1;
               end
            end else begin
               tx_cnt_r <= tx_cnt_r - ONE_D;
            end
         end
      end
   end

   // ---------------- RX engine ----------------
   state_t rx_state_r, rx_next_s;
   logic [DIVW-1:0] rx_cnt_r, rx_bdiv_r;
   logic [7:0] rx_sh_r;
   logic [2:0] rx_bit_r;
   logic rx_s1_r, rx_s2_r, rx_prev_r, rx_line_s;
   logic rx_tick_s, rx_fall_s, rx_push_s, rx_fe_s, rx_ovr_s, rx_pop_s;

`ifdef ACIA_FIFO_LOOPBACK_EN
   assign rx_line_s = loop_r ? tx_r : rx_s2_r;
   assign tx        = tx_pin_r;

   // tx pin is parked high while looped back
   always_ff @(posedge clk) begin
      if (!rst_n || srst_s) tx_pin_r <= 1'b1;
      else                  tx_pin_r <= tx_bit_s | loop_r;
   end
`else
   assign rx_line_s = rx_s2_r;
   assign tx        = tx_r;
`endif

   assign rx_tick_s = (rx_cnt_r == ZERO_D);
   assign rx_fall_s = rx_prev_r && !rx_line_s;
   assign rx_pop_s  = data_rd_s && !rxf_empty_s;

   // input synchronizer and edge history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1_r   <= 1'b1;
         rx_s2_r   <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_s1_r   <= rx;
         rx_s2_r   <= rx_s1_r;
         rx_prev_r <= rx_line_s;
      end
   end

   // RX next state; a start bit that is high again at mid-bit is treated as a glitch
   always_comb begin
      rx_next_s = rx_state_r;
      case (rx_state_r)
         S_IDLE:  rx_next_s = rx_fall_s ? S_START : S_IDLE;
         S_START: rx_next_s = !rx_tick_s ? S_START : (rx_line_s ? S_IDLE : S_DATA);
         S_DATA:  rx_next_s = (rx_tick_s && rx_bit_r == 3'd7) ? S_STOP : S_DATA;
         S_STOP:  rx_next_s = rx_tick_s ? S_IDLE : S_STOP;
         default: rx_next_s = S_IDLE;
      endcase
   end

   // RX outputs at the mid-stop sample
   always_comb begin
      rx_push_s = 1'b0;
      rx_fe_s   = 1'b0;
      if (rx_state_r == S_STOP && rx_tick_s) begin
         rx_push_s = rx_line_s;
         rx_fe_s   = !rx_line_s;
      end else begin
         rx_push_s = 1'b0;
         rx_fe_s   = 1'b0;
      end
      rx_ovr_s = rx_push_s && rxf_full_s && !rx_pop_s;
   end

   // RX state register and datapath
   always_ff @(posedge clk) begin
      if (!rst_n || srst_s) begin
         rx_state_r <= S_IDLE;
         rx_cnt_r   <= ZERO_D;
         rx_bdiv_r  <= MIN_DIV;
         rx_sh_r    <= 8'h00;
         rx_bit_r   <= 3'd0;
      end else begin
         rx_state_r <= rx_next_s;
         if (rx_state_r == S_IDLE) begin
            if (rx_fall_s) begin
               rx_bdiv_r <= div_r;
               rx_cnt_r  <= (div_r >> 1) - ONE_D;
            end
         end else if (rx_tick_s) begin
            rx_cnt_r <= rx_bdiv_r - ONE_D;
            if (rx_state_r == S_START) rx_bit_r <= 3'd0;
            if (rx_state_r == S_DATA) begin
               rx_sh_r  <= {rx_line_s, rx_sh_r[7:1]};
               rx_bit_r <= rx_bit_r + 3'd1;
            end
         end else begin
            rx_cnt_r <= rx_cnt_r - ONE_D;
         end
      end
   end

   // ---------------- FIFOs, flags, bus ----------------
   acia_fifo_buf #(.AW(FIFO_AW)) u_txf (
      .clk(clk), .rst_n(rst_n), .flush(srst_s), .push(data_wr_s), .wdata(din),
      .pop(tx_pop_s), .rdata(txf_rdata), .count(txf_count)
   );

   acia_fifo_buf #(.AW(FIFO_AW)) u_rxf (
      .clk(clk), .rst_n(rst_n), .flush(srst_s), .push(rx_push_s), .wdata(rx_sh_r),
      .pop(rx_pop_s), .rdata(rxf_rdata), .count(rxf_count)
   );

   assign txf_empty_s = (txf_count == EMPTY);
   assign txf_full_s  = (txf_count == DEPTH);
   assign rxf_empty_s = (rxf_count == EMPTY);
   assign rxf_full_s  = (rxf_count == DEPTH);
   assign rx_half_s   = (rxf_count >= HALF);

   // error flags: a set in the same cycle as the status read wins over the clear
   always_ff @(posedge clk) begin
      if (!rst_n || srst_s) begin
         ovr_r <= 1'b0;
         fe_r  <= 1'b0;
      end else begin
         if (rx_ovr_s)       ovr_r <= 1'b1;
         else if (stat_rd_s) ovr_r <= 1'b0;
         if (rx_fe_s)        fe_r  <= 1'b1;
         else if (stat_rd_s) fe_r  <= 1'b0;
      end
   end

   // read data select
   always_comb begin
      rd_mux_s = 8'h00;
      case (addr)
         2'd0:    rd_mux_s = {irq_r, txf_full_s, ovr_r, fe_r, rx_half_s, 1'b0, !txf_full_s, !rxf_empty_s};
         2'd1:    rd_mux_s = rxf_empty_s ? last_rd_r : rxf_rdata;
         2'd2:    rd_mux_s = div16_s[7:0];
         2'd3:    rd_mux_s = div16_s[15:8];
         default: rd_mux_s = 8'h00;
      endcase
   end

   // bus read data, last returned RX byte and interrupt
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_r    <= 8'h00;
         last_rd_r <= 8'h00;
         irq_r     <= 1'b0;
      end else begin
         if (rd_s)     dout_r    <= rd_mux_s;
         if (rx_pop_s) last_rd_r <= rxf_rdata;
         irq_r <= (rie_r && !rxf_empty_s) ||
                  (txc_r == 2'b01 && txf_empty_s && tx_state_r == S_IDLE);
      end
   end

   assign dout = dout_r;
   assign irq  = irq_r;
endmodule

// File: tb/tb_acia_fifo.sv
// Directed bench for acia_fifo: reset, divisor, TX waveform, RX, overrun, framing, glitch, soft reset.

module tb_acia_fifo;
   logic       clk = 1'b0;
   logic       rst_n, cs, we, rx;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       tx, irq;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   acia_fifo #(.FIFO_AW(2)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
      .dout(dout), .rx(rx), .tx(tx), .irq(irq)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // called at a negedge; strobe is sampled at the following posedge
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      cs = 1'b0;
      d = dout;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(16);
      end
      rx = stop;
      tick(16);
      rx = 1'b1;
   endtask

   logic [7:0]  d;
   logic [19:0] exp_line;

   initial begin
      rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00; rx = 1'b1;
      tick(2);
      rst_n = 1'b1;
      check("rst_tx", {7'd0, tx}, 8'h01);
      check("rst_irq", {7'd0, irq}, 8'h00);
      check("rst_dout", dout, 8'h00);
      bus_read(2'd0, d); check("rst_status", d, 8'h02);
      bus_read(2'd2, d); check("rst_div_lo", d, 8'h0A);
      bus_read(2'd3, d); check("rst_div_hi", d, 8'h01);

      // divisor: clamp to 8, then 16
      bus_write(2'd3, 8'h00);
      bus_write(2'd2, 8'h03);
      bus_read(2'd2, d); check("div_clamp", d, 8'h08);
      bus_write(2'd2, 8'h10);
      bus_read(2'd2, d); check("div_16", d, 8'h10);

      // TX: two back-to-back frames with TXC=01
      bus_write(2'd0, 8'h20);
      tick(1);
      check("txc_idle_irq", {7'd0, irq}, 8'h01);
      exp_line = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
      bus_write(2'd1, 8'h55);
      bus_write(2'd1, 8'hA3);
      check("tx_pre_start", {7'd0, tx}, 8'h01);
      tick(1);
      check("tx_start_lat", {7'd0, tx}, 8'h00);
      tick(15);
      check("tx_start_end", {7'd0, tx}, 8'h00);
      tick(1);
      check("tx_bit0_edge", {7'd0, tx}, 8'h01);
      tick(8);
      check("tx_line_k1", {7'd0, tx}, {7'd0, exp_line[1]});
      for (int k = 2; k < 20; k++) begin
         tick(16);
         check($sformatf("tx_line_k%0d", k), {7'd0, tx}, {7'd0, exp_line[k]});
         if (k == 9) check("tx_busy_irq", {7'd0, irq}, 8'h00);
      end
      tick(7);
      check("txc_irq_early", {7'd0, irq}, 8'h00);
      tick(1);
      check("txc_irq_done", {7'd0, irq}, 8'h01);
      bus_write(2'd0, 8'h00);

      // RX single byte, RIE interrupt
      send_rx(8'h3C, 1'b1);
      bus_read(2'd0, d); check("rx_status", d, 8'h03);
      bus_write(2'd0, 8'h80);
      tick(1);
      check("rie_irq", {7'd0, irq}, 8'h01);
      bus_read(2'd1, d); check("rx_data", d, 8'h3C);
      tick(1);
      check("rie_irq_clr", {7'd0, irq}, 8'h00);
      bus_read(2'd1, d); check("rx_empty_read", d, 8'h3C);
      bus_read(2'd0, d); check("rx_status_empty", d, 8'h02);
      bus_write(2'd0, 8'h00);

      // overrun: 5 bytes into a 4-deep FIFO
      for (int i = 0; i < 5; i++) send_rx(8'((i + 1) * 17), 1'b1);
      bus_read(2'd0, d); check("ovr_status", d, 8'h2B);
      bus_read(2'd0, d); check("ovr_cleared", d, 8'h0B);
      for (int i = 0; i < 4; i++) begin
         bus_read(2'd1, d);
         check($sformatf("ovr_data%0d", i), d, 8'((i + 1) * 17));
      end
      bus_read(2'd0, d); check("ovr_drained", d, 8'h02);

      // framing error, then a short glitch
      send_rx(8'h41, 1'b0);
      bus_read(2'd0, d); check("fe_status", d, 8'h12);
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(40);
      bus_read(2'd0, d); check("glitch_status", d, 8'h02);

      // soft reset during TX data bit 3
      bus_write(2'd1, 8'h77);
      bus_write(2'd1, 8'h12);
      tick(73);
      check("srst_bit3", {7'd0, tx}, 8'h00);
      bus_write(2'd0, 8'h03);
      check("srst_tx", {7'd0, tx}, 8'h01);
      bus_read(2'd0, d); check("srst_status", d, 8'h02);
      bus_write(2'd0, 8'h00);
      tick(10);
      check("srst_flushed", {7'd0, tx}, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/acia_fifo.md
# acia_fifo

Parametrised MC6850-style serial port for the 6502 bus: register-compatible control/status/data at addresses 0/1, plus a run-time programmable baud divisor and TX/RX FIFOs of configurable depth. Contains its own 8N1 transmit and receive engines. Sits on the CPU data bus, chip-selected by the address decoder, and drives the CPU IRQ line.

## Interface
Parameters:
- CLK_FREQ, 30650000, system clock in Hz
- DEF_BAUD, 115200, baud rate after reset; reset divisor = CLK_FREQ/DEF_BAUD
- DIVW, 16, baud divisor width in bits
- FIFO_AW, 4, FIFO address width; each FIFO holds 2**FIFO_AW bytes

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cs  in  1  chip select
- we  in  1  write enable
- addr  in  2  register select: 0 ctrl/status, 1 data, 2 divisor low, 3 divisor high
- din  in  8  bus write data
- dout  out  8  registered bus read data, reset 8'h00
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, reset 1
- irq  out  1  high-true interrupt, reset 0

## Operation
- Control write (addr 0): din[7] RIE, din[6:5] TXC, din[4] LOOP, din[1:0] CDS. CDS==2'b11 is soft reset: flushes both FIFOs, clears error flags, aborts both engines (tx=1); held while CDS==11.
- Status read (addr 0): {irq, tx_full, ovr, fe, rx_half, 0, ~tx_full, ~rx_empty}. rx_half = RX count >= half depth. The read clears ovr and fe; a flag set in the same cycle as the read stays set.
- Data write (addr 1): pushes din into TX FIFO; ignored when full.
- Data read (addr 1): dout <= RX head, pop. Empty RX FIFO returns last head value, no pop.
- Divisor (addr 2/3): reads/writes the DIVW-bit bit period in clocks; bits above DIVW ignored/read 0. Values below 8 are stored as 8. Consumed only at frame start.
- TX engine: idle with FIFO non-empty -> pop, latch divisor, send start, 8 data LSB first, stop; each bit exactly divisor clocks. States IDLE, START, DATA, STOP.
- RX engine: 2-flop synchronizer. States IDLE, START, DATA, STOP. Falling edge -> START; at divisor/2 still low -> DATA, else back to IDLE (glitch). Bits sampled every divisor clocks from there. Stop=1 -> push byte. Stop=0 -> fe=1, byte discarded. Push into full FIFO -> ovr=1, byte dropped, FIFO contents unchanged.
- irq = (RIE & ~rx_empty) | (TXC==2'b01 & tx_empty & tx engine idle).
- FIFOs: simultaneous push and pop when full/empty both succeed correctly (push into full allowed only if popping same cycle); pointers wrap modulo depth.

## Timing
- dout valid the cycle after a read strobe (cs & ~we), as in the 6850 bus model.
- Register writes take effect at the strobe clock edge.
- First TX start bit drives tx 2 cycles after the data write into an empty FIFO with idle engine; back-to-back frames have no idle gap.
- RX byte visible (~rx_empty) 1 cycle after mid-stop sample.
- Reset or soft reset mid-frame: tx=1 the following cycle, partial RX byte discarded.
- Divisor change mid-frame does not alter the current frame.

## Configuration
- ACIA_FIFO_LOOPBACK_EN defined: LOOP=1 routes tx to the RX engine input internally; tx pin held at 1; bit 4 of control is stored.
- Not defined: LOOP bit ignored and not stored; RX always from rx pin; no loopback mux synthesised.

## Test plan
- Reset: rst_n=0 2 cycles -> tx=1, irq=0, dout=00, status read = 8'h02, divisor reads 266 (0x010A).
- TX: divisor=16, write 0x55 then 0xA3 -> tx waveforms 10 bits each, 16 clocks/bit, no gap; TXC=01 raises irq after second stop bit.
- RX: drive 0x3C at divisor 16 -> status bit0=1; data read returns 0x3C; RIE=1 gives irq until read.
- Overrun: FIFO_AW=2, send 5 bytes without reads -> first 4 bytes read back in order, ovr=1 on status read, then 0 on next read.
- Framing/glitch: 0x41 with stop=0 -> fe=1, FIFO empty; 3-clock low pulse -> no byte, no flags.
- Soft reset mid-frame: write ctrl 0x03 during TX data bit 3 -> tx=1 next cycle, FIFOs empty, status 8'h02.
